// File: rtl/edge_pack_buffer_if.sv
// Pixel-in / packed-word-out bus of edge_pack_buffer.
// Carries ovf_count only when OUTBUF_OVF_COUNT_EN is defined.
interface edge_pack_buffer_if #(
    parameter int PIX_W  = 1,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
);
    logic [PIX_W-1:0]  edge_pixel;
    logic              out_en;
    logic              img_done;
    logic              write_out_enable;
    logic              in_ready;
    logic [WORD_W-1:0] out_pixel;
    logic [ADDR_W-1:0] write_addr;
    logic              out_empty;
    logic              out_full;
    logic              overflow;
    logic              done;
`ifdef OUTBUF_OVF_COUNT_EN
    logic [15:0]       ovf_count;
`endif

    modport master (
        output edge_pixel, out_en, img_done, write_out_enable,
        input  in_ready, out_pixel, write_addr, out_empty, out_full, overflow, done
`ifdef OUTBUF_OVF_COUNT_EN
        , input ovf_count
`endif
    );

    modport slave (
        input  edge_pixel, out_en, img_done, write_out_enable,
        output in_ready, out_pixel, write_addr, out_empty, out_full, overflow, done
`ifdef OUTBUF_OVF_COUNT_EN
        , output ovf_count
`endif
    );
endinterface

// File: rtl/edge_pack_buffer.sv
// Packs PIX_W-bit edge results into WORD_W-bit words, queues them in a show-ahead FIFO with
// auto-incrementing write address; flushes partial words at end of image. Option: OUTBUF_OVF_COUNT_EN.
module edge_pack_buffer #(
    parameter int                WORD_W     = 32,
    parameter int                PIX_W      = 1,
    parameter int                FIFO_DEPTH = 4,
    parameter int                ADDR_W     = 32,
    parameter int                ADDR_STEP  = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic               clk,
    input  logic               n_rst,
    edge_pack_buffer_if.slave  bus
);
    localparam int PPW   = WORD_W / PIX_W;
    localparam int CNT_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DONE} state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [ADDR_W-1:0]   write_addr_q, write_addr_d;
    logic                overflow_q, overflow_d;
    logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];

    logic                empty, full, pop, push, word_last, in_ready, accept, drop;
    logic [WORD_W-1:0]   shifted, push_word;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign pop       = bus.write_out_enable && !empty;
    assign word_last = (pix_cnt_q == CNT_W'(PPW - 1));
    // A pop this cycle frees the slot the completing pixel needs, so it may still be accepted.
    assign in_ready  = (state_q == ST_RUN) && !(full && word_last && !pop);
    assign accept    = bus.out_en && in_ready;
    assign drop      = bus.out_en && !in_ready;
    assign shifted   = (pack_q << PIX_W) | WORD_W'(bus.edge_pixel);

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        pack_d       = pack_q;
        pix_cnt_d    = pix_cnt_q;
        push         = 1'b0;
        push_word    = shifted;
        write_addr_d = write_addr_q;
        overflow_d   = drop;

        if (accept) begin
            if (word_last) begin
                push      = 1'b1;
                pack_d    = '0;
                pix_cnt_d = '0;
            end else begin
                pack_d    = shifted;
                pix_cnt_d = pix_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_RUN: begin
                if (bus.img_done) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (pix_cnt_q != '0) begin
                    // Left-align the partial word; the vacated LSBs fill with zeros.
                    if (!full || pop) begin
                        push      = 1'b1;
                        push_word = pack_q << (PIX_W * (PPW - int'(pix_cnt_q)));
                        pack_d    = '0;
                        pix_cnt_d = '0;
                    end
                end else if (empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase

        if (pop) write_addr_d = write_addr_q + ADDR_W'(ADDR_STEP);
        if (state_q == ST_DONE) write_addr_d = BASE_ADDR;

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_RUN;
            pack_q       <= '0;
            pix_cnt_q    <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            write_addr_q <= BASE_ADDR;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pack_q       <= pack_d;
            pix_cnt_q    <= pix_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            write_addr_q <= write_addr_d;
            overflow_q   <= overflow_d;
        end
    end

    // NOTE: FIFO storage is not reset; the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_word;
    end

`ifdef OUTBUF_OVF_COUNT_EN
    logic [15:0] ovf_count_q, ovf_count_d;

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (state_q == ST_DONE) ovf_count_d = '0;
        else if (drop && ovf_count_q != 16'hFFFF) ovf_count_d = ovf_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) ovf_count_q <= '0;
        else        ovf_count_q <= ovf_count_d;
    end

    assign bus.ovf_count = ovf_count_q;
`endif

    assign bus.in_ready   = in_ready;
    assign bus.out_pixel  = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.write_addr = write_addr_q;
    assign bus.out_empty  = empty;
    assign bus.out_full   = full;
    assign bus.overflow   = overflow_q;
    assign bus.done       = (state_q == ST_DONE);
endmodule

// File: tb/tb_edge_pack_buffer.sv
// Directed bench for edge_pack_buffer: a per-cycle vector table on an 8-bit-pixel instance and
// hand-written sequences on a default (1-bit pixel) instance.
module tb_edge_pack_buffer;
    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    edge_pack_buffer_if #(.PIX_W(1), .WORD_W(32), .ADDR_W(32)) d_if ();
    edge_pack_buffer_if #(.PIX_W(8), .WORD_W(32), .ADDR_W(32)) p_if ();

    edge_pack_buffer u_d (.clk(clk), .n_rst(n_rst), .bus(d_if.slave));
    edge_pack_buffer #(.PIX_W(8)) u_p (.clk(clk), .n_rst(n_rst), .bus(p_if.slave));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic [7:0]  pix;
        logic        pop;
        logic        idone;
        logic        rdy;    // in_ready before the edge
        logic        empty;  // the rest: after the edge
        logic        full;
        logic [31:0] head;
        logic [31:0] addr;
        logic        ovf;
        logic        done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic [7:0] pix, input logic pop,
                                input logic idone, input logic rdy, input logic empty,
                                input logic full, input logic [31:0] head,
                                input logic [31:0] addr, input logic ovf, input logic done);
        vec_t v;
        v.en = en; v.pix = pix; v.pop = pop; v.idone = idone; v.rdy = rdy; v.empty = empty;
        v.full = full; v.head = head; v.addr = addr; v.ovf = ovf; v.done = done;
        return v;
    endfunction

    task automatic d_pixels(input int n, input logic v);
        for (int i = 0; i < n; i++) begin
            d_if.out_en     = 1'b1;
            d_if.edge_pixel = v;
            @(posedge clk); #1;
        end
        d_if.out_en = 1'b0;
    endtask

    task automatic d_pop();
        d_if.write_out_enable = 1'b1;
        @(posedge clk); #1;
        d_if.write_out_enable = 1'b0;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int  waited;
        bit  saw_done;

        n_rst = 1'b0;
        d_if.out_en = 0; d_if.edge_pixel = 0; d_if.img_done = 0; d_if.write_out_enable = 0;
        p_if.out_en = 0; p_if.edge_pixel = 0; p_if.img_done = 0; p_if.write_out_enable = 0;

        // ---- reset values ----
        @(posedge clk); #1;
        check("rst.out_empty",  d_if.out_empty,  1);
        check("rst.out_full",   d_if.out_full,   0);
        check("rst.write_addr", d_if.write_addr, 0);
        check("rst.out_pixel",  d_if.out_pixel,  0);
        check("rst.in_ready",   d_if.in_ready,   1);
        check("rst.overflow",   d_if.overflow,   0);
        check("rst.done",       d_if.done,       0);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // ---- table: PIX_W=8 instance ----
        vecs.push_back(mk(1, 8'h11, 0, 0, 1, 1, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 8'h22, 0, 0, 1, 1, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 8'h33, 0, 0, 1, 1, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 8'h44, 0, 0, 1, 0, 0, 32'h11223344, 0, 0, 0));
        vecs.push_back(mk(1, 8'h55, 0, 0, 1, 0, 0, 32'h11223344, 0, 0, 0));
        vecs.push_back(mk(1, 8'h66, 0, 0, 1, 0, 0, 32'h11223344, 0, 0, 0));
        vecs.push_back(mk(1, 8'h77, 0, 0, 1, 0, 0, 32'h11223344, 0, 0, 0));
        vecs.push_back(mk(1, 8'h88, 0, 0, 1, 0, 0, 32'h11223344, 0, 0, 0));
        vecs.push_back(mk(1, 8'h99, 0, 0, 1, 0, 0, 32'h11223344, 0, 0, 0));
        vecs.push_back(mk(1, 8'hAA, 0, 0, 1, 0, 0, 32'h11223344, 0, 0, 0));
        vecs.push_back(mk(1, 8'hBB, 0, 0, 1, 0, 0, 32'h11223344, 0, 0, 0));
        vecs.push_back(mk(1, 8'hCC, 0, 0, 1, 0, 0, 32'h11223344, 0, 0, 0));
        vecs.push_back(mk(1, 8'hDD, 0, 0, 1, 0, 0, 32'h11223344, 0, 0, 0));
        vecs.push_back(mk(1, 8'hEE, 0, 0, 1, 0, 0, 32'h11223344, 0, 0, 0));
        vecs.push_back(mk(1, 8'hFF, 0, 0, 1, 0, 0, 32'h11223344, 0, 0, 0));
        vecs.push_back(mk(1, 8'h01, 0, 0, 1, 0, 1, 32'h11223344, 0, 0, 0));
        vecs.push_back(mk(1, 8'h02, 0, 0, 1, 0, 1, 32'h11223344, 0, 0, 0));
        vecs.push_back(mk(1, 8'h03, 0, 0, 1, 0, 1, 32'h11223344, 0, 0, 0));
        vecs.push_back(mk(1, 8'h04, 0, 0, 1, 0, 1, 32'h11223344, 0, 0, 0));
        vecs.push_back(mk(1, 8'h05, 1, 0, 1, 0, 1, 32'h55667788, 4, 0, 0));  // push+pop at full
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 32'h99AABBCC, 8, 0, 0));
        vecs.push_back(mk(1, 8'h06, 0, 0, 1, 0, 0, 32'h99AABBCC, 8, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 32'hDDEEFF01, 12, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 32'h02030405, 16, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 0, 32'h0,        20, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 0, 32'h0,        20, 0, 0));  // pop when empty
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 1, 0, 32'h0,        20, 0, 0));  // img_done
        vecs.push_back(mk(1, 8'hAB, 0, 0, 0, 0, 0, 32'h06000000, 20, 1, 0));  // flush + drop
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 32'h0,        24, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 32'h0,        24, 0, 1));  // DONE
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 32'h0,        0,  0, 0));  // addr reload
        vecs.push_back(mk(1, 8'h07, 0, 0, 1, 1, 0, 32'h0,        0,  0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            p_if.out_en           = vecs[i].en;
            p_if.edge_pixel       = vecs[i].pix;
            p_if.write_out_enable = vecs[i].pop;
            p_if.img_done         = vecs[i].idone;
            #1;
            check($sformatf("p%0d.in_ready", i), p_if.in_ready, vecs[i].rdy);
            @(posedge clk); #1;
            check($sformatf("p%0d.out_empty", i),  p_if.out_empty,  vecs[i].empty);
            check($sformatf("p%0d.out_full", i),   p_if.out_full,   vecs[i].full);
            check($sformatf("p%0d.out_pixel", i),  p_if.out_pixel,  vecs[i].head);
            check($sformatf("p%0d.write_addr", i), p_if.write_addr, vecs[i].addr);
            check($sformatf("p%0d.overflow", i),   p_if.overflow,   vecs[i].ovf);
            check($sformatf("p%0d.done", i),       p_if.done,       vecs[i].done);
        end
        p_if.out_en = 0; p_if.write_out_enable = 0; p_if.img_done = 0;

        // ---- 32 ones, then one pop ----
        do_reset();
        d_pixels(32, 1'b1);
        check("ones.out_pixel", d_if.out_pixel, 32'hFFFF_FFFF);
        check("ones.out_empty", d_if.out_empty, 0);
        d_pop();
        check("ones.write_addr", d_if.write_addr, 4);
        check("ones.out_empty",  d_if.out_empty,  1);

        // ---- fill to full, overflow, drain ----
        do_reset();
        for (int w = 0; w < 4; w++) d_pixels(32, w[0]);
        check("fill.out_full", d_if.out_full, 1);
        for (int i = 0; i < 31; i++) begin
            d_if.out_en = 1'b1; d_if.edge_pixel = 1'b1; #1;
            check($sformatf("fill.ready%0d", i), d_if.in_ready, 1);
            @(posedge clk); #1;
        end
        d_if.out_en = 1'b1; #1;
        check("fill.ready_last", d_if.in_ready, 0);
        @(posedge clk); #1;
        d_if.out_en = 1'b0;
        check("fill.overflow",      d_if.overflow, 1);
        check("fill.full_kept",     d_if.out_full, 1);
`ifdef OUTBUF_OVF_COUNT_EN
        check("fill.ovf_count", d_if.ovf_count, 1);
`endif
        @(posedge clk); #1;
        check("fill.overflow_end", d_if.overflow, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d.out_pixel", k), d_if.out_pixel,
                  k[0] ? 32'hFFFF_FFFF : 32'h0);
            check($sformatf("drain%0d.write_addr", k), d_if.write_addr, k * 4);
            d_pop();
        end
        check("drain.out_empty", d_if.out_empty, 1);

        // ---- partial flush and done ----
        do_reset();
        d_pixels(5, 1'b1);
        d_if.img_done = 1'b1;
        @(posedge clk); #1;
        d_if.img_done = 1'b0;
        waited = 0;
        while (d_if.out_empty && waited < 10) begin @(posedge clk); #1; waited++; end
        check("flush.out_empty",  d_if.out_empty,  0);
        check("flush.out_pixel",  d_if.out_pixel,  32'hF800_0000);
        check("flush.write_addr", d_if.write_addr, 0);
        check("flush.in_ready",   d_if.in_ready,   0);
        d_pop();
        saw_done = 1'b0;
        waited   = 0;
        while (!saw_done && waited < 10) begin
            if (d_if.done) saw_done = 1'b1;
            else begin @(posedge clk); #1; waited++; end
        end
        check("flush.done_seen", saw_done, 1);
        @(posedge clk); #1;
        check("flush.done_pulse", d_if.done,       0);
        check("flush.addr_reset", d_if.write_addr, 0);

        // ---- async reset in FLUSH with 2 words queued ----
        do_reset();
        d_pixels(64, 1'b1);
        d_if.out_en = 1'b1; d_if.edge_pixel = 1'b1; d_if.img_done = 1'b1;
        @(posedge clk); #1;
        d_if.out_en = 1'b0; d_if.img_done = 1'b0;
        check("arst.pre_empty", d_if.out_empty, 0);
        check("arst.pre_ready", d_if.in_ready,  0);
        n_rst = 1'b0; #1;
        check("arst.out_empty", d_if.out_empty, 1);
        check("arst.out_full",  d_if.out_full,  0);
        check("arst.done",      d_if.done,      0);
        check("arst.in_ready",  d_if.in_ready,  1);
        @(posedge clk); #1;
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("arst.no_done%0d", i), d_if.done, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
